// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and defaults for the pipeline sequencing controller
// Contents: FSM state encoding, default widths, scoreboard-entry struct.
package pipe_pkg;

    localparam int REG_W_DEF = 6;
    localparam int MC_W_DEF  = 3;

    // Scoreboard addresses are stored at a fixed width so the entry struct
    // does not depend on the REG_W parameter of any one instance.
    localparam int SB_ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_MULTI = 2'd2,
        ST_FLUSH = 2'd3
    } pipe_state_t;

    typedef struct packed {
        logic                 vld;
        logic                 wr;
        logic [SB_ADDR_W-1:0] addr;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{vld: 1'b0, wr: 1'b0, addr: '0};

endpackage

// File: rtl/pipe_hazard_cmp.sv
// rtl/pipe_hazard_cmp.sv - RAW compare of the operand-stage instruction against one scoreboard entry
// Ports: op_valid/op_rd_a/op_rd_b/op_a/op_b - operand-stage reads
//        entry - scoreboard entry (vld, wr, addr)
//        hit_a/hit_b - operand A/B reads the entry's destination
module pipe_hazard_cmp
    import pipe_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             op_valid,
    input  logic             op_rd_a,
    input  logic             op_rd_b,
    input  logic [REG_W-1:0] op_a,
    input  logic [REG_W-1:0] op_b,
    input  sb_entry_t        entry,
    output logic             hit_a,
    output logic             hit_b
);

    logic live;

    // Only a valid entry that actually writes a register can conflict.
    // Address 0 is compared like any other register.
    assign live  = op_valid & entry.vld & entry.wr;
    assign hit_a = live & op_rd_a & (SB_ADDR_W'(op_a) == entry.addr);
    assign hit_b = live & op_rd_b & (SB_ADDR_W'(op_b) == entry.addr);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline advance arbiter: RAW stalls, multi-cycle execute, branch flush
// Build option: PIPE_CTRL_FWD_EN enables writeback forwarding (fwd_a/fwd_b).
// Ports: clk/reset - core clock, synchronous active-high reset
//        op_* - operand-stage instruction (valid, reads, addresses, write, multi-cycle latency)
//        ex_branch_taken - branch in execute resolved taken
//        fetch_en/opr_en/ex_en - stage-register load enables
//        ex_bubble - load NOP into execute; flush - clear fetch and operand registers
//        fwd_a/fwd_b - take operand from writeback; state - current FSM state
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int MC_W  = MC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic             op_rd_a,
    input  logic             op_rd_b,
    input  logic [REG_W-1:0] op_a,
    input  logic [REG_W-1:0] op_b,
    input  logic             op_wr,
    input  logic [REG_W-1:0] op_c,
    input  logic             op_mc,
    input  logic [MC_W-1:0]  op_lat,
    input  logic             ex_branch_taken,
    output logic             fetch_en,
    output logic             opr_en,
    output logic             ex_en,
    output logic             ex_bubble,
    output logic             flush,
    output logic             fwd_a,
    output logic             fwd_b,
    output logic [1:0]       state
);

    pipe_state_t     state_q;
    pipe_state_t     state_d;
    logic [MC_W-1:0] mc_cnt;
    logic [MC_W-1:0] mc_cnt_d;
    sb_entry_t       ex_q;
    sb_entry_t       wb_q;

    logic op_live;
    logic ex_hit_a;
    logic ex_hit_b;
    logic wb_hit_a;
    logic wb_hit_b;
    logic raw_stall;
    logic mc_start;

    // The operand stage holds wrong-path contents during the FLUSH cycle.
    assign op_live = op_valid & (state_q != ST_FLUSH);

    pipe_hazard_cmp #(.REG_W(REG_W)) u_cmp_ex (
        .op_valid (op_live),
        .op_rd_a  (op_rd_a),
        .op_rd_b  (op_rd_b),
        .op_a     (op_a),
        .op_b     (op_b),
        .entry    (ex_q),
        .hit_a    (ex_hit_a),
        .hit_b    (ex_hit_b)
    );

    pipe_hazard_cmp #(.REG_W(REG_W)) u_cmp_wb (
        .op_valid (op_live),
        .op_rd_a  (op_rd_a),
        .op_rd_b  (op_rd_b),
        .op_a     (op_a),
        .op_b     (op_b),
        .entry    (wb_q),
        .hit_a    (wb_hit_a),
        .hit_b    (wb_hit_b)
    );

`ifdef PIPE_CTRL_FWD_EN
    // Writeback results are bypassed, so only an execute-stage producer stalls.
    assign raw_stall = ex_hit_a | ex_hit_b;
`else
    assign raw_stall = ex_hit_a | ex_hit_b | wb_hit_a | wb_hit_b;
    assign fwd_a     = 1'b0;
    assign fwd_b     = 1'b0;
`endif

    // op_lat == 0 is treated as a single-cycle op regardless of op_mc.
    assign mc_start = op_live & op_mc & (op_lat != '0);

    always_comb begin
        state_d   = state_q;
        mc_cnt_d  = mc_cnt;
        fetch_en  = 1'b1;
        opr_en    = 1'b1;
        ex_en     = 1'b1;
        ex_bubble = 1'b0;
        flush     = 1'b0;
`ifdef PIPE_CTRL_FWD_EN
        fwd_a     = 1'b0;
        fwd_b     = 1'b0;
`endif
        if (reset) begin
            fetch_en  = 1'b0;
            opr_en    = 1'b0;
            ex_bubble = 1'b1;
            flush     = 1'b1;
        end else begin
            case (state_q)
                ST_MULTI: begin
                    // Everything holds; branch resolution waits for execute to finish.
                    fetch_en = 1'b0;
                    opr_en   = 1'b0;
                    ex_en    = 1'b0;
                    if (mc_cnt <= MC_W'(1)) begin
                        mc_cnt_d = '0;
                        state_d  = ST_RUN;
                    end else begin
                        mc_cnt_d = mc_cnt - MC_W'(1);
                    end
                end
                ST_FLUSH: begin
                    ex_bubble = 1'b1;
                    state_d   = ST_RUN;
                end
                default: begin
                    if (ex_branch_taken) begin
                        opr_en    = 1'b0;
                        ex_bubble = 1'b1;
                        flush     = 1'b1;
                        state_d   = ST_FLUSH;
                    end else if (raw_stall) begin
                        fetch_en  = 1'b0;
                        opr_en    = 1'b0;
                        ex_bubble = 1'b1;
                        state_d   = ST_STALL;
                    end else begin
                        // MULTI is entered only when the op actually loads into execute.
                        if (mc_start) begin
                            mc_cnt_d = op_lat;
                            state_d  = ST_MULTI;
                        end else begin
                            state_d  = ST_RUN;
                        end
`ifdef PIPE_CTRL_FWD_EN
                        fwd_a = wb_hit_a;
                        fwd_b = wb_hit_b;
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            mc_cnt  <= '0;
            ex_q    <= SB_EMPTY;
            wb_q    <= SB_EMPTY;
        end else begin
            state_q <= state_d;
            mc_cnt  <= mc_cnt_d;
            if (ex_en) begin
                wb_q <= ex_q;
                if (ex_bubble) begin
                    ex_q <= SB_EMPTY;
                end else begin
                    ex_q <= '{vld: op_live, wr: op_wr, addr: SB_ADDR_W'(op_c)};
                end
            end else begin
                // Execute is held, so nothing retires into writeback this cycle.
                wb_q <= SB_EMPTY;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

    localparam int REG_W = 6;
    localparam int MC_W  = 3;

    // Output vector order: {fetch_en, opr_en, ex_en, ex_bubble, flush, fwd_a, fwd_b}
    localparam logic [6:0] O_RUN   = 7'b1110000;
    localparam logic [6:0] O_RUNFA = 7'b1110010;
    localparam logic [6:0] O_RUNFB = 7'b1110001;
    localparam logic [6:0] O_STALL = 7'b0011000;
    localparam logic [6:0] O_MULTI = 7'b0000000;
    localparam logic [6:0] O_FLENT = 7'b1011100;
    localparam logic [6:0] O_FLUSH = 7'b1111000;
    localparam logic [6:0] O_RST   = 7'b0011100;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_MULTI = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic             clk = 1'b0;
    logic             reset;
    logic             op_valid;
    logic             op_rd_a;
    logic             op_rd_b;
    logic [REG_W-1:0] op_a;
    logic [REG_W-1:0] op_b;
    logic             op_wr;
    logic [REG_W-1:0] op_c;
    logic             op_mc;
    logic [MC_W-1:0]  op_lat;
    logic             ex_branch_taken;
    logic             fetch_en;
    logic             opr_en;
    logic             ex_en;
    logic             ex_bubble;
    logic             flush;
    logic             fwd_a;
    logic             fwd_b;
    logic [1:0]       state;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [6:0] outs;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    pipe_ctrl #(.REG_W(REG_W), .MC_W(MC_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .op_valid        (op_valid),
        .op_rd_a         (op_rd_a),
        .op_rd_b         (op_rd_b),
        .op_a            (op_a),
        .op_b            (op_b),
        .op_wr           (op_wr),
        .op_c            (op_c),
        .op_mc           (op_mc),
        .op_lat          (op_lat),
        .ex_branch_taken (ex_branch_taken),
        .fetch_en        (fetch_en),
        .opr_en          (opr_en),
        .ex_en           (ex_en),
        .ex_bubble       (ex_bubble),
        .flush           (flush),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .state           (state)
    );

    always #5 clk = ~clk;

    task automatic set_op(input logic v, input logic rda, input int a, input logic rdb, input int b,
                          input logic wr, input int c, input logic mc, input int lat);
        op_valid = v;
        op_rd_a  = rda;
        op_a     = REG_W'(a);
        op_rd_b  = rdb;
        op_b     = REG_W'(b);
        op_wr    = wr;
        op_c     = REG_W'(c);
        op_mc    = mc;
        op_lat   = MC_W'(lat);
    endtask

    task automatic set_nop();
        set_op(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    // Queue the expected response for the inputs now applied, then advance one cycle.
    task automatic cyc(input string name, input logic [1:0] st, input logic [6:0] outs);
        exp_t e;
        e.name = name;
        e.st   = st;
        e.outs = outs;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name);
        checks++;
        if (dut.mc_cnt !== 3'd0) begin
            failures++;
            $display("FAIL %s: mc_cnt=%0d expected 0", name, dut.mc_cnt);
        end
    endtask

    // Monitor: outputs are combinational, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (state !== mon_e.st ||
                {fetch_en, opr_en, ex_en, ex_bubble, flush, fwd_a, fwd_b} !== mon_e.outs) begin
                failures++;
                $display("FAIL %s: state=%0d outs=%b expected state=%0d outs=%b", mon_e.name, state,
                         {fetch_en, opr_en, ex_en, ex_bubble, flush, fwd_a, fwd_b},
                         mon_e.st, mon_e.outs);
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        reset           = 1'b1;
        ex_branch_taken = 1'b0;
        set_nop();
        repeat (2) @(posedge clk);
        #1;
        cyc("rst_hold", S_RUN, O_RST);
        check_cnt("rst_cnt");
        reset = 1'b0;
        cyc("idle", S_RUN, O_RUN);

        // Dependent instruction directly behind a producer of r5
        set_op(1, 0, 0, 0, 0, 1, 5, 0, 0);  cyc("prod_r5", S_RUN, O_RUN);
        set_op(1, 1, 5, 0, 0, 1, 6, 0, 0);  cyc("raw_ex_stall", S_RUN, O_STALL);
`ifdef PIPE_CTRL_FWD_EN
        cyc("raw_wb_fwd", S_STALL, O_RUNFA);
`else
        cyc("raw_wb_stall", S_STALL, O_STALL);
        cyc("raw_clear", S_STALL, O_RUN);
`endif
        set_nop();
        cyc("drain_a0", S_RUN, O_RUN);
        cyc("drain_a1", S_RUN, O_RUN);

        // Matching address on A but A not read
        set_op(1, 0, 0, 0, 0, 1, 5, 0, 0);  cyc("prod_r5b", S_RUN, O_RUN);
        set_op(1, 0, 5, 1, 7, 0, 0, 0, 0);  cyc("no_rd_a", S_RUN, O_RUN);
        set_nop();
        cyc("drain_b0", S_RUN, O_RUN);
        cyc("drain_b1", S_RUN, O_RUN);

        // r0 producer, one unrelated instruction, then reader of r0 on B
        set_op(1, 0, 0, 0, 0, 1, 0, 0, 0);  cyc("prod_r0", S_RUN, O_RUN);
        set_op(1, 0, 0, 0, 0, 0, 0, 0, 0);  cyc("gap", S_RUN, O_RUN);
        set_op(1, 0, 0, 1, 0, 1, 7, 0, 0);
`ifdef PIPE_CTRL_FWD_EN
        cyc("gap_fwd_b", S_RUN, O_RUNFB);
`else
        cyc("gap_stall", S_RUN, O_STALL);
        cyc("gap_clear", S_STALL, O_RUN);
`endif
        set_nop();
        cyc("drain_c0", S_RUN, O_RUN);
        cyc("drain_c1", S_RUN, O_RUN);

        // Multi-cycle op, latency 3, with a branch that must be ignored
        set_op(1, 0, 0, 0, 0, 1, 10, 1, 3); cyc("mc3_load", S_RUN, O_RUN);
        set_nop();
        cyc("mc3_c1", S_MULTI, O_MULTI);
        ex_branch_taken = 1'b1;
        cyc("mc3_c2_br", S_MULTI, O_MULTI);
        ex_branch_taken = 1'b0;
        cyc("mc3_c3", S_MULTI, O_MULTI);
        cyc("mc3_done", S_RUN, O_RUN);
        check_cnt("mc3_cnt");

        // op_mc with zero latency is single-cycle
        set_op(1, 0, 0, 0, 0, 0, 0, 1, 0);  cyc("mc0_load", S_RUN, O_RUN);
        set_nop();
        cyc("mc0_next", S_RUN, O_RUN);
        cyc("drain_d0", S_RUN, O_RUN);

        // Hazard on a multi-cycle op: stall first, MULTI only once it loads
        set_op(1, 0, 0, 0, 0, 1, 3, 0, 0);  cyc("prod_r3", S_RUN, O_RUN);
        set_op(1, 1, 3, 0, 0, 1, 4, 1, 2);  cyc("mch_s1", S_RUN, O_STALL);
`ifdef PIPE_CTRL_FWD_EN
        cyc("mch_fwd_load", S_STALL, O_RUNFA);
`else
        cyc("mch_s2", S_STALL, O_STALL);
        cyc("mch_load", S_STALL, O_RUN);
`endif
        set_nop();
        cyc("mch_m1", S_MULTI, O_MULTI);
        cyc("mch_m2", S_MULTI, O_MULTI);
        cyc("mch_done", S_RUN, O_RUN);
        cyc("drain_e0", S_RUN, O_RUN);

        // Taken branch in RUN; wrong-path op (writes r12, multi-cycle) in FLUSH is ignored
        set_op(1, 0, 0, 0, 0, 1, 12, 0, 0);
        ex_branch_taken = 1'b1;
        cyc("br_run", S_RUN, O_FLENT);
        ex_branch_taken = 1'b0;
        set_op(1, 0, 0, 0, 0, 1, 12, 1, 2); cyc("flush_cyc", S_FLUSH, O_FLUSH);
        set_op(1, 1, 12, 0, 0, 0, 0, 0, 0); cyc("post_flush", S_RUN, O_RUN);
        set_nop();
        cyc("drain_f0", S_RUN, O_RUN);
        cyc("drain_f1", S_RUN, O_RUN);

        // Taken branch while stalled
        set_op(1, 0, 0, 0, 0, 1, 5, 0, 0);  cyc("prod_r5c", S_RUN, O_RUN);
        set_op(1, 1, 5, 0, 0, 0, 0, 0, 0);  cyc("stall_pre_br", S_RUN, O_STALL);
        ex_branch_taken = 1'b1;
        cyc("br_stall", S_STALL, O_FLENT);
        ex_branch_taken = 1'b0;
        set_nop();
        cyc("flush_cyc2", S_FLUSH, O_FLUSH);
        cyc("post_flush2", S_RUN, O_RUN);

        // Reset in the second cycle of a latency-5 multi-cycle op
        set_op(1, 0, 0, 0, 0, 1, 9, 1, 5);  cyc("mc5_load", S_RUN, O_RUN);
        set_nop();
        cyc("mc5_c1", S_MULTI, O_MULTI);
        reset = 1'b1;
        cyc("mc5_rst", S_MULTI, O_RST);
        check_cnt("mc5_rst_cnt");
        cyc("rst_held", S_RUN, O_RST);
        reset = 1'b0;
        cyc("post_rst", S_RUN, O_RUN);
        check_cnt("post_rst_cnt");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d responses unchecked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
